// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
//
// Request/response bus of the data-memory controller.
//
// Request channel (master -> slave unless noted):
//   req_valid     request present
//   req_ready     slave -> master, request accepted on req_valid && req_ready
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  zero-extend (1) or sign-extend (0) load data
//   req_addr      byte address, ADDR_W bits
//   req_wdata     store data, LSB-aligned
//
// Response channel (slave -> master unless noted):
//   rsp_valid     response present
//   rsp_ready     master -> slave, response consumed on rsp_valid && rsp_ready
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       access error for this response
//
// Modports: master (requester side), slave (the controller).
// -----------------------------------------------------------------------------
interface dmem_ctrl_if #(
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//
// Single-port data-memory controller with a user-data region and a stack
// region, one-cycle load/store latency, a held response under backpressure,
// a sticky first-error capture and an optional stack low-watermark.
//
// Memory map (byte addresses):
//   [0, STACK_BASE)           data array,  DATA_WORDS  x 32 bit
//   [STACK_BASE, STACK_TOP)   stack array, STACK_WORDS x 32 bit
//   >= STACK_TOP              unmapped, any request there is an error
//   STACK_BASE = DATA_WORDS*4, STACK_TOP = STACK_BASE + STACK_WORDS*4
//
// Ports:
//   clk         clock, single domain
//   rst         synchronous active-high reset
//   bus         dmem_ctrl_if.slave request/response handshake
//   dbg_addr    debug byte address (read-only side port)
//   dbg_rdata   word at dbg_addr>>2, combinational; 0 when unmapped
//   err_sticky  an error has been accepted since the last clear
//   err_addr    address of the first error since the last clear
//   err_clr     clears err_sticky/err_addr (a simultaneous error wins)
//   wmark       lowest stack word address stored; STACK_TOP when unused
//
// Configuration macro:
//   DMEM_STACK_WMARK_EN  when defined, wmark tracks the lowest stack word
//                        written; otherwise wmark is tied to STACK_TOP.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_WORDS  = 2816,
  parameter int STACK_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  dmem_ctrl_if.slave        bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] wmark
);

  // ---------------------------------------------------------------------------
  // Address map
  // ---------------------------------------------------------------------------
  localparam int STACK_BASE = DATA_WORDS * 4;
  localparam int STACK_TOP  = STACK_BASE + STACK_WORDS * 4;
  localparam int DIDX_W     = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
  localparam int SIDX_W     = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

  localparam logic [ADDR_W-1:0] STACK_TOP_A = ADDR_W'(STACK_TOP);

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STACK,
    REG_NONE
  } region_e;

  typedef struct packed {
    region_e           region;
    logic [DIDX_W-1:0] didx;
    logic [SIDX_W-1:0] sidx;
  } map_t;

  // Shared by the request path and the debug port so both see one map.
  // Comparisons are done on a 32-bit copy so the region bounds never
  // truncate, whatever ADDR_W is.
  function automatic map_t decode(input logic [ADDR_W-1:0] addr);
    logic [31:0] a;
    map_t        m;
    a        = 32'(addr);
    m.region = REG_NONE;
    m.didx   = '0;
    m.sidx   = '0;
    if (a < 32'(STACK_BASE)) begin
      m.region = REG_DATA;
      m.didx   = DIDX_W'(a >> 2);
    end else if (a < 32'(STACK_TOP)) begin
      m.region = REG_STACK;
      m.sidx   = SIDX_W'((a - 32'(STACK_BASE)) >> 2);
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] data_mem  [DATA_WORDS];
  logic [31:0] stack_mem [STACK_WORDS];

  // ---------------------------------------------------------------------------
  // Handshake state
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  state_e      state;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // A request is taken only in IDLE; anything on req_* during RESP is ignored.
  logic accept;
  assign accept = (state == ST_IDLE) && bus.req_valid;

  // ---------------------------------------------------------------------------
  // Request decode, error check, lane steering
  // ---------------------------------------------------------------------------
  map_t        req_map;
  logic        req_err;
  logic [31:0] req_word;
  logic [31:0] req_shift;
  logic [31:0] load_data;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;

  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and turn it into a latch.
  always_comb begin
    req_map   = decode(bus.req_addr);
    req_err   = 1'b0;
    req_word  = '0;
    req_shift = '0;
    load_data = '0;
    wr_be     = 4'b0000;
    wr_lanes  = '0;

    unique case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (req_map.region == REG_NONE) req_err = 1'b1;

    // Old word at the request address, read before the store edge.
    unique case (req_map.region)
      REG_DATA:  req_word = data_mem[req_map.didx];
      REG_STACK: req_word = stack_mem[req_map.sidx];
      default:   req_word = '0;
    endcase

    // Bring the addressed byte/half down to bit 0, then extend.
    req_shift = req_word >> {bus.req_addr[1:0], 3'b000};
    unique case (bus.req_size)
      2'b00: load_data = bus.req_unsigned ? {24'h0, req_shift[7:0]}
                                          : {{24{req_shift[7]}}, req_shift[7:0]};
      2'b01: load_data = bus.req_unsigned ? {16'h0, req_shift[15:0]}
                                          : {{16{req_shift[15]}}, req_shift[15:0]};
      default: load_data = req_shift;
    endcase

    // Replicate the store data across lanes; the byte enables pick which
    // lanes actually land, so unwritten lanes keep their old contents.
    unique case (bus.req_size)
      2'b00: begin
        wr_be    = 4'b0001 << bus.req_addr[1:0];
        wr_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = bus.req_wdata;
      end
    endcase
  end

  // A store accepted in the same cycle as rst is dropped.
  logic do_write;
  assign do_write = accept && bus.req_we && !req_err && !rst;

  // ---------------------------------------------------------------------------
  // Array write port
  // ---------------------------------------------------------------------------
  // NOTE: the arrays are deliberately not reset; rst only aborts the
  // handshake, so stored contents survive it and stay readable.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          if (req_map.region == REG_DATA)
            data_mem[req_map.didx][8*b +: 8] <= wr_lanes[8*b +: 8];
          else
            stack_mem[req_map.sidx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered response
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register in this block samples pre-edge values and ordering is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state       <= ST_RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (bus.req_we || req_err) ? 32'h0 : load_data;
          end
        end
        ST_RESP: begin
          // Response is held unchanged until the consumer takes it.
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky first-error capture
  // ---------------------------------------------------------------------------
  // A new error overrides a coincident clear; otherwise only the first error
  // after a clear is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (accept && req_err && (!err_sticky || err_clr)) begin
      err_sticky <= 1'b1;
      err_addr   <= bus.req_addr;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug read port (never writes, never errors)
  // ---------------------------------------------------------------------------
  map_t dbg_map;

  always_comb begin
    dbg_map   = decode(dbg_addr);
    dbg_rdata = '0;
    unique case (dbg_map.region)
      REG_DATA:  dbg_rdata = data_mem[dbg_map.didx];
      REG_STACK: dbg_rdata = stack_mem[dbg_map.sidx];
      default:   dbg_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stack low-watermark
  // ---------------------------------------------------------------------------
`ifdef DMEM_STACK_WMARK_EN
  logic [ADDR_W-1:0] wmark_q;
  logic [ADDR_W-1:0] req_word_addr;

  assign req_word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      wmark_q <= STACK_TOP_A;
    end else if (do_write && (req_map.region == REG_STACK) &&
                 (req_word_addr < wmark_q)) begin
      wmark_q <= req_word_addr;
    end
  end

  assign wmark = wmark_q;
`else
  assign wmark = STACK_TOP_A;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Self-checking bench for dmem_ctrl: a table of directed load/store vectors,
// hand-written sequences for error capture, backpressure, reset in RESP and
// the stack watermark, then randomized traffic compared against a byte-array
// reference model.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int ADDR_W      = 16;
  localparam int DATA_WORDS  = 2816;
  localparam int STACK_WORDS = 256;
  localparam int STACK_BASE  = DATA_WORDS * 4;
  localparam int STACK_TOP   = STACK_BASE + STACK_WORDS * 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_rdata;
  logic              err_sticky;
  logic [ADDR_W-1:0] err_addr;
  logic              err_clr;
  logic [ADDR_W-1:0] wmark;

  dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_WORDS  (DATA_WORDS),
    .STACK_WORDS (STACK_WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .err_clr    (err_clr),
    .wmark      (wmark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: flat little-endian byte array plus error/watermark state
  // ---------------------------------------------------------------------------
  logic [7:0]  mmem [STACK_TOP];
  logic        m_sticky = 1'b0;
  logic [15:0] m_eaddr  = 16'h0;
  logic [15:0] m_wmark  = 16'(STACK_TOP);

  task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [15:0] addr, input logic [31:0] wdata,
                              input logic clr, output logic [31:0] rdata,
                              output logic err);
    int          n;
    logic [31:0] v;
    n     = 1 << size;
    err   = (size == 2'd3) || ((int'(addr) % n) != 0) || (int'(addr) >= STACK_TOP);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mmem[int'(addr) + i] = wdata[8*i +: 8];
`ifdef DMEM_STACK_WMARK_EN
        if ((int'(addr) >= STACK_BASE) && ((addr & 16'hFFFC) < m_wmark))
          m_wmark = addr & 16'hFFFC;
`endif
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[int'(addr) + i];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rdata = v;
      end
    end
    if (err && (!m_sticky || clr)) begin
      m_sticky = 1'b1;
      m_eaddr  = addr;
    end else if (clr) begin
      m_sticky = 1'b0;
      m_eaddr  = 16'h0;
    end
  endtask

  function automatic logic [31:0] model_word(input logic [15:0] a);
    logic [31:0] v;
    int          base;
    base = int'(a) & ~3;
    v    = 32'h0;
    if (base < STACK_TOP)
      for (int i = 0; i < 4; i++) v[8*i +: 8] = mmem[base + i];
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // One full transaction. Entered and left just after a falling edge with
  // the controller idle; checks acceptance and single-cycle latency.
  // ---------------------------------------------------------------------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        input logic clr, output logic [31:0] rdata,
                        output logic err);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = 1'b1;
    err_clr          = clr;
    check("req_ready_idle", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    err_clr       = 1'b0;
    check("rsp_valid_latency", bus.rsp_valid, 1'b1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid_drop", bus.rsp_valid, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [15:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  logic [31:0] act_r, exp_r;
  logic        act_e, exp_e;
  logic [15:0] a16;
  logic [31:0] hold_r;

  initial begin
    // Sizes: 0 byte, 1 half, 2 word, 3 illegal.
    vecs.push_back(mk(1, 2, 0, 16'h0010, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 2, 0, 16'h0010, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 2, 0, 16'h0010, 32'h11223344, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 16'h0013, 32'h12345680, 32'h0,        0));
    vecs.push_back(mk(0, 2, 0, 16'h0010, 32'h0,        32'h80223344, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0013, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0013, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk(1, 2, 0, 16'h0000, 32'h01020304, 32'h0,        0));
    vecs.push_back(mk(1, 2, 0, 16'h0002, 32'hAAAAAAAA, 32'h0,        1));
    vecs.push_back(mk(1, 2, 0, 16'h3000, 32'h55555555, 32'h0,        1));
    vecs.push_back(mk(0, 2, 0, 16'h0000, 32'h0,        32'h01020304, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0012, 32'hFFFFA5F0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 16'h0012, 32'h0,        32'hFFFFA5F0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0010, 32'h0,        32'h00003344, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0011, 32'h0,        32'h00000033, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0011, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 3, 0, 16'h0010, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 2, 0, 16'h2C00, 32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(mk(0, 2, 0, 16'h2C00, 32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 0, 0, 16'h2FFF, 32'h000000F1, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 16'h2FFF, 32'h0,        32'h000000F1, 0));
    vecs.push_back(mk(0, 2, 0, 16'h3000, 32'h0,        32'h0,        1));

    // ---- reset ----
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
    err_clr          = 1'b0;
    dbg_addr         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready",  bus.req_ready, 1'b1);
    check("rst_rsp_valid",  bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata",  bus.rsp_rdata, 32'h0);
    check("rst_rsp_err",    bus.rsp_err,   1'b0);
    check("rst_err_sticky", err_sticky,    1'b0);
    check("rst_err_addr",   err_addr,      16'h0);
    check("rst_wmark",      wmark,         16'h3000);

    // ---- directed table ----
    foreach (vecs[i]) begin
      model_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   1'b0, exp_r, exp_e);
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             1'b0, act_r, act_e);
      check($sformatf("vec%0d_rdata", i), act_r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i),   act_e, vecs[i].exp_err);
    end

    dbg_addr = 16'h0012; #1;
    check("dbg_unaligned_word", dbg_rdata, 32'hA5F03344);
    dbg_addr = 16'h2C00; #1;
    check("dbg_stack_base", dbg_rdata, 32'hCAFEF00D);
    dbg_addr = 16'h3000; #1;
    check("dbg_out_of_range", dbg_rdata, 32'h0);

    // ---- error capture ----
    check("first_err_sticky", err_sticky, 1'b1);
    check("first_err_addr",   err_addr,   16'h0002);
    model_access(0, 2, 0, 16'h3004, 32'h0, 1'b1, exp_r, exp_e);
    do_req(0, 2, 0, 16'h3004, 32'h0, 1'b1, act_r, act_e);
    check("clr_err_rsp_err", act_e,      1'b1);
    check("clr_err_sticky",  err_sticky, 1'b1);
    check("clr_err_addr",    err_addr,   16'h3004);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr  = 1'b0;
    m_sticky = 1'b0;
    m_eaddr  = 16'h0;
    check("clr_only_sticky", err_sticky, 1'b0);
    check("clr_only_addr",   err_addr,   16'h0);

    // ---- backpressure: response held, new requests ignored ----
    model_access(0, 2, 0, 16'h0010, 32'h0, 1'b0, exp_r, exp_e);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 16'h0010;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'hFFFF_FFFF;
    check("bp_rsp_valid0", bus.rsp_valid, 1'b1);
    check("bp_rsp_rdata0", bus.rsp_rdata, exp_r);
    hold_r = bus.rsp_rdata;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_rsp_valid_c%0d", c), bus.rsp_valid, 1'b1);
      check($sformatf("bp_rsp_rdata_c%0d", c), bus.rsp_rdata, hold_r);
      check($sformatf("bp_req_ready_c%0d", c), bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", bus.rsp_valid, 1'b0);
    check("bp_release_ready", bus.req_ready, 1'b1);
    dbg_addr = 16'h0010; #1;
    check("bp_store_ignored", dbg_rdata, model_word(16'h0010));

    // ---- reset while in RESP, plus a store coinciding with rst ----
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 16'h0010;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rr_in_resp", bus.rsp_valid, 1'b1);
    rst           = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h2C00;
    bus.req_wdata = 32'h0BADBAD0;
    @(posedge clk);
    @(negedge clk);
    check("rr_rsp_valid_next", bus.rsp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    m_sticky      = 1'b0;
    m_eaddr       = 16'h0;
    m_wmark       = 16'(STACK_TOP);
    check("rr_req_ready", bus.req_ready, 1'b1);
    check("rr_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rr_rsp_err",   bus.rsp_err,   1'b0);
    check("rr_wmark",     wmark,         16'h3000);
    dbg_addr = 16'h2C00; #1;
    check("rr_store_dropped", dbg_rdata, 32'hCAFEF00D);
    dbg_addr = 16'h0010; #1;
    check("rr_data_kept", dbg_rdata, model_word(16'h0010));

    // ---- stack watermark ----
    begin
      logic [15:0] wm_addr [3];
      logic [15:0] wm_exp  [3];
      wm_addr[0] = 16'h2FF0; wm_addr[1] = 16'h2F00; wm_addr[2] = 16'h2F80;
`ifdef DMEM_STACK_WMARK_EN
      wm_exp[0] = 16'h2FF0; wm_exp[1] = 16'h2F00; wm_exp[2] = 16'h2F00;
`else
      wm_exp[0] = 16'h3000; wm_exp[1] = 16'h3000; wm_exp[2] = 16'h3000;
`endif
      for (int k = 0; k < 3; k++) begin
        model_access(1, 2, 0, wm_addr[k], 32'h5A5A0000 + k, 1'b0, exp_r, exp_e);
        do_req(1, 2, 0, wm_addr[k], 32'h5A5A0000 + k, 1'b0, act_r, act_e);
        check($sformatf("wm_err_%0d", k), act_e, 1'b0);
        check($sformatf("wm_val_%0d", k), wmark, wm_exp[k]);
      end
    end

    // ---- randomized traffic against the model ----
    for (int w = 0; w < 16; w++) begin
      for (int r = 0; r < 2; r++) begin
        a16 = (r == 0) ? 16'(16'h0100 + 4*w) : 16'(16'h2FC0 + 4*w);
        hold_r = $urandom;
        model_access(1, 2, 0, a16, hold_r, 1'b0, exp_r, exp_e);
        do_req(1, 2, 0, a16, hold_r, 1'b0, act_r, act_e);
        check("init_err", act_e, exp_e);
      end
    end

    for (int t = 0; t < 300; t++) begin
      logic        we, uns, clr;
      logic [1:0]  size;
      logic [31:0] wd;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      a16 = 16'(16'h0100 + $urandom_range(0, 63));
      else if (sel < 8) a16 = 16'(16'h2FC0 + $urandom_range(0, 63));
      else              a16 = 16'($urandom_range(16'h3000, 16'hFFFF));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      clr  = ($urandom_range(0, 7) == 0);
      wd   = $urandom;
      model_access(we, size, uns, a16, wd, clr, exp_r, exp_e);
      do_req(we, size, uns, a16, wd, clr, act_r, act_e);
      check($sformatf("rnd%0d_rdata", t), act_r, exp_r);
      check($sformatf("rnd%0d_err", t),   act_e, exp_e);
      check($sformatf("rnd%0d_sticky", t), err_sticky, m_sticky);
      check($sformatf("rnd%0d_eaddr", t),  err_addr,   m_eaddr);
      check($sformatf("rnd%0d_wmark", t),  wmark,      m_wmark);
      dbg_addr = ($urandom_range(0, 1) == 0) ? 16'(16'h0100 + $urandom_range(0, 63))
                                             : 16'(16'h2FC0 + $urandom_range(0, 63));
      #1;
      check($sformatf("rnd%0d_dbg", t), dbg_rdata, model_word(dbg_addr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
